stream_reg_fifo: RTL and testbench

STREAM_REG_FIFO -- requirements
Module: stream_reg_fifo

---
 rtl/stream_fifo_pkg.sv | 19 +
 rtl/stream_reg_fifo_if.sv | 23 ++
 rtl/stream_fifo_ptr.sv | 37 +++
 rtl/stream_reg_fifo.sv | 99 +++++++++
 tb/tb_stream_reg_fifo.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/stream_fifo_pkg.sv
// rtl/stream_fifo_pkg.sv - shared widths and parameter ranges for the stream FIFO
package stream_fifo_pkg;

  localparam int W_MIN     = 1;
  localparam int W_MAX     = 1024;
  localparam int DEPTH_MIN = 2;
  localparam int DEPTH_MAX = 32;

  // Occupancy must represent 0..DEPTH inclusive.
  function automatic int level_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Pointers address 0..DEPTH-1; keep at least one bit.
  function automatic int ptr_width(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/stream_reg_fifo_if.sv
// rtl/stream_reg_fifo_if.sv - producer/consumer handshake bundle for the stream FIFO
interface stream_reg_fifo_if #(
  parameter int W = 8
);

  logic         data_in_valid;
  logic [W-1:0] data_in;
  logic         data_in_ready;
  logic         data_out_ready;
  logic [W-1:0] data_out;
  logic         data_out_valid;

  modport master (
    output data_in_valid, data_in, data_out_ready,
    input  data_in_ready, data_out, data_out_valid
  );

  modport slave (
    input  data_in_valid, data_in, data_out_ready,
    output data_in_ready, data_out, data_out_valid
  );

endinterface

// File: rtl/stream_fifo_ptr.sv
// rtl/stream_fifo_ptr.sv - modulo-DEPTH wrap counter with increment and clear
module stream_fifo_ptr
  import stream_fifo_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clr_i,
  input  logic                        inc_i,
  output logic [ptr_width(DEPTH)-1:0] ptr_o
);

  localparam int PW = ptr_width(DEPTH);

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;

  // Next pointer: clear wins, otherwise step and wrap from DEPTH-1 to 0.
  always_comb begin
    ptr_d = ptr_q;
    if (clr_i) begin
      ptr_d = '0;
    end else if (inc_i) begin
      ptr_d = (ptr_q == PW'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
    end
  end

  // Pointer register with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/stream_reg_fifo.sv
// rtl/stream_reg_fifo.sv - register-based stream FIFO with registered flags and no bypass
module stream_reg_fifo
  import stream_fifo_pkg::*;
#(
  parameter int W          = 8,
  parameter int DEPTH      = 4,
  parameter int AFULL_LVL  = 3,
  parameter int AEMPTY_LVL = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  stream_reg_fifo_if.slave              bus,
  output logic [level_width(DEPTH)-1:0] level,
  output logic                          almost_full,
  output logic                          almost_empty
);

  localparam int LW = level_width(DEPTH);
  localparam int PW = ptr_width(DEPTH);

  if (W < W_MIN || W > W_MAX) begin : g_bad_w
    $error("stream_reg_fifo: W=%0d out of range", W);
  end
  if (DEPTH < DEPTH_MIN || DEPTH > DEPTH_MAX) begin : g_bad_depth
    $error("stream_reg_fifo: DEPTH=%0d out of range", DEPTH);
  end
  if (AFULL_LVL < 1 || AFULL_LVL > DEPTH) begin : g_bad_afull
    $error("stream_reg_fifo: AFULL_LVL=%0d out of range", AFULL_LVL);
  end
  if (AEMPTY_LVL < 0 || AEMPTY_LVL > DEPTH - 1) begin : g_bad_aempty
    $error("stream_reg_fifo: AEMPTY_LVL=%0d out of range", AEMPTY_LVL);
  end

  logic [W-1:0]  mem_q [DEPTH];
  logic [LW-1:0] count_q;
  logic [LW-1:0] count_d;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          wr_en;
  logic          rd_en;

  // Handshake flags come only from the count register, so no input reaches them.
  assign bus.data_in_ready  = (count_q != LW'(DEPTH));
  assign bus.data_out_valid = (count_q != '0);
  assign bus.data_out       = mem_q[rd_ptr];

  // Flush suppresses both transfers in its cycle.
  assign wr_en = bus.data_in_valid  && bus.data_in_ready  && !flush;
  assign rd_en = bus.data_out_valid && bus.data_out_ready && !flush;

  stream_fifo_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (flush),
    .inc_i (wr_en),
    .ptr_o (wr_ptr)
  );

  stream_fifo_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (flush),
    .inc_i (rd_en),
    .ptr_o (rd_ptr)
  );

  // Occupancy next state: flush empties, lone write/read steps by one.
  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else if (wr_en && !rd_en) begin
      count_d = count_q + 1'b1;
    end else if (rd_en && !wr_en) begin
      count_d = count_q - 1'b1;
    end
  end

  // Occupancy register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  // Storage: only accepted words are written; reset clears every entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[wr_ptr] <= bus.data_in;
    end
  end

  assign level        = count_q;
  assign almost_full  = (count_q >= LW'(AFULL_LVL));
  assign almost_empty = (count_q <= LW'(AEMPTY_LVL));

endmodule

// File: tb/tb_stream_reg_fifo.sv
// tb/tb_stream_reg_fifo.sv - self-checking bench for stream_reg_fifo at DEPTH 4 and 3
`timescale 1ns/100ps
module tb_stream_reg_fifo;

  logic clk;
  logic rst_n;
  logic flush4;
  logic flush3;
  logic [2:0] level4;
  logic [1:0] level3;
  logic af4, ae4, af3, ae3;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] m4[$];
  logic [7:0] m3[$];

  stream_reg_fifo_if #(.W(8)) if4();
  stream_reg_fifo_if #(.W(8)) if3();

  stream_reg_fifo #(.W(8), .DEPTH(4), .AFULL_LVL(3), .AEMPTY_LVL(1)) dut4 (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush4),
    .bus          (if4),
    .level        (level4),
    .almost_full  (af4),
    .almost_empty (ae4)
  );

  stream_reg_fifo #(.W(8), .DEPTH(3), .AFULL_LVL(2), .AEMPTY_LVL(1)) dut3 (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush3),
    .bus          (if3),
    .level        (level3),
    .almost_full  (af3),
    .almost_empty (ae3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Queue models: a transfer happens when the queue state permits it and flush is low.
  always @(posedge clk or negedge rst_n) begin
    logic w, r;
    if (!rst_n) m4.delete();
    else if (flush4) m4.delete();
    else begin
      w = if4.data_in_valid && (m4.size() < 4);
      r = if4.data_out_ready && (m4.size() > 0);
      if (r) void'(m4.pop_front());
      if (w) m4.push_back(if4.data_in);
    end
  end

  always @(posedge clk or negedge rst_n) begin
    logic w, r;
    if (!rst_n) m3.delete();
    else if (flush3) m3.delete();
    else begin
      w = if3.data_in_valid && (m3.size() < 3);
      r = if3.data_out_ready && (m3.size() > 0);
      if (r) void'(m3.pop_front());
      if (w) m3.push_back(if3.data_in);
    end
  end

  // Per-cycle comparison of both DUTs against their models.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("d4_ready", if4.data_in_ready, m4.size() != 4);
      chk("d4_valid", if4.data_out_valid, m4.size() != 0);
      chk("d4_level", level4, m4.size());
      chk("d4_afull", af4, m4.size() >= 3);
      chk("d4_aempty", ae4, m4.size() <= 1);
      if (m4.size() != 0) chk("d4_data", if4.data_out, m4[0]);
      chk("d3_ready", if3.data_in_ready, m3.size() != 3);
      chk("d3_valid", if3.data_out_valid, m3.size() != 0);
      chk("d3_level", level3, m3.size());
      chk("d3_afull", af3, m3.size() >= 2);
      chk("d3_aempty", ae3, m3.size() <= 1);
      if (m3.size() != 0) chk("d3_data", if3.data_out, m3[0]);
    end
  end

  task automatic cyc4(input logic v, input logic [7:0] d, input logic r, input logic f);
    if4.data_in_valid = v; if4.data_in = d; if4.data_out_ready = r; flush4 = f;
    @(negedge clk);
  endtask

  task automatic cyc3(input logic v, input logic [7:0] d, input logic r, input logic f);
    if3.data_in_valid = v; if3.data_in = d; if3.data_out_ready = r; flush3 = f;
    @(negedge clk);
  endtask

  task automatic chk_reset4(input string tag);
    chk({tag, "_ready"}, if4.data_in_ready, 1);
    chk({tag, "_valid"}, if4.data_out_valid, 0);
    chk({tag, "_data"}, if4.data_out, 8'h00);
    chk({tag, "_level"}, level4, 0);
    chk({tag, "_afull"}, af4, 0);
    chk({tag, "_aempty"}, ae4, 1);
  endtask

  logic [7:0] wdat [4];
  logic [2:0] elvl [4];
  logic       eaf  [4];
  logic       eae  [4];
  logic       erdy [4];

  initial begin
    wdat = '{8'h11, 8'h22, 8'h33, 8'h44};
    elvl = '{3'd1, 3'd2, 3'd3, 3'd4};
    eaf  = '{1'b0, 1'b0, 1'b1, 1'b1};
    eae  = '{1'b1, 1'b0, 1'b0, 1'b0};
    erdy = '{1'b1, 1'b1, 1'b1, 1'b0};

    rst_n = 1'b0; flush4 = 1'b0; flush3 = 1'b0;
    if4.data_in_valid = 1'b0; if4.data_in = '0; if4.data_out_ready = 1'b0;
    if3.data_in_valid = 1'b0; if3.data_in = '0; if3.data_out_ready = 1'b0;
    #2;
    chk_reset4("rst");
    chk("rst_d3_ready", if3.data_in_ready, 1);
    chk("rst_d3_aempty", ae3, 1);
    #10 rst_n = 1'b1;
    @(negedge clk);

    // Fill DEPTH=4 with the consumer stalled.
    for (int i = 0; i < 4; i++) begin
      cyc4(1'b1, wdat[i], 1'b0, 1'b0);
      chk("fill_level", level4, elvl[i]);
      chk("fill_afull", af4, eaf[i]);
      chk("fill_aempty", ae4, eae[i]);
      chk("fill_ready", if4.data_in_ready, erdy[i]);
      chk("fill_head", if4.data_out, 8'h11);
    end
    cyc4(1'b1, 8'h66, 1'b0, 1'b0);
    chk("full_hold_level", level4, 4);
    chk("full_hold_head", if4.data_out, 8'h11);

    // Read while full: no pass-through, 0x55 enters one cycle later.
    cyc4(1'b1, 8'h55, 1'b1, 1'b0);
    chk("rwf_level", level4, 3);
    chk("rwf_head", if4.data_out, 8'h22);
    cyc4(1'b1, 8'h55, 1'b1, 1'b0);
    chk("rwf2_level", level4, 3);
    chk("rwf2_head", if4.data_out, 8'h33);
    cyc4(1'b0, 8'h00, 1'b1, 1'b0);
    chk("drain_head0", if4.data_out, 8'h44);
    cyc4(1'b0, 8'h00, 1'b1, 1'b0);
    chk("drain_head1", if4.data_out, 8'h55);
    cyc4(1'b0, 8'h00, 1'b1, 1'b0);
    chk("drain_valid", if4.data_out_valid, 0);

    // Flush at level 2 together with a write and a read.
    cyc4(1'b1, 8'h01, 1'b0, 1'b0);
    cyc4(1'b1, 8'h02, 1'b0, 1'b0);
    chk("pre_flush_level", level4, 2);
    cyc4(1'b1, 8'hAA, 1'b1, 1'b1);
    chk("flush_level", level4, 0);
    chk("flush_valid", if4.data_out_valid, 0);
    for (int i = 0; i < 3; i++) begin
      cyc4(1'b0, 8'h00, 1'b1, 1'b0);
      chk("post_flush_valid", if4.data_out_valid, 0);
    end

    // Short asynchronous reset at level 3, then a single write.
    cyc4(1'b1, 8'h61, 1'b0, 1'b0);
    cyc4(1'b1, 8'h62, 1'b0, 1'b0);
    cyc4(1'b1, 8'h63, 1'b0, 1'b0);
    chk("pre_rst_level", level4, 3);
    #1 rst_n = 1'b0;
    if4.data_in_valid = 1'b1; if4.data_in = 8'h77; if4.data_out_ready = 1'b0;
    #1 chk_reset4("arst");
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_level", level4, 1);
    chk("post_rst_head", if4.data_out, 8'h77);
    cyc4(1'b0, 8'h00, 1'b1, 1'b0);
    chk("post_rst_alone", if4.data_out_valid, 0);

    // DEPTH=3 streaming with both sides always ready.
    for (int k = 1; k <= 10; k++) begin
      cyc3(1'b1, 8'(k), 1'b1, 1'b0);
      chk("stream_level", level3, 1);
      chk("stream_head", if3.data_out, k);
    end
    cyc3(1'b0, 8'h00, 1'b1, 1'b0);
    chk("stream_empty", if3.data_out_valid, 0);

    // Random traffic on both instances, with occasional flush.
    for (int n = 0; n < 10000; n++) begin
      if4.data_in_valid = 1'($urandom); if4.data_in = 8'($urandom);
      if4.data_out_ready = 1'($urandom); flush4 = ($urandom_range(0, 63) == 0);
      if3.data_in_valid = 1'($urandom); if3.data_in = 8'($urandom);
      if3.data_out_ready = 1'($urandom); flush3 = ($urandom_range(0, 63) == 0);
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
